// File: rtl/frame_crop_if.sv
// frame_crop_if: pixel stream bundle for frame_crop_buffer.
//   in_*  : upstream source stream (raster order, valid/ready)
//   out_* : cropped stream with SOF/EOL/LAST markers (valid/ready)
// slave modport is the buffer's view; master modport is the producer/consumer side.
interface frame_crop_if #(parameter int PIX_W = 8);
  logic [PIX_W-1:0] in_pix;
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] out_pix;
  logic             out_valid;
  logic             out_ready;
  logic             out_sof;
  logic             out_eol;
  logic             out_last;

  modport slave  (input  in_pix, in_valid, out_ready,
                  output in_ready, out_pix, out_valid, out_sof, out_eol, out_last);
  modport master (output in_pix, in_valid, out_ready,
                  input  in_ready, out_pix, out_valid, out_sof, out_eol, out_last);
endinterface

// File: rtl/frame_crop_buffer.sv
// frame_crop_buffer: stores one SRC_W x SRC_H frame, then streams a CROP_W x CROP_H
// window positioned at (crop_x, crop_y) sampled on start.
// Ports:
//   clk, reset          : single clock, synchronous active-high reset
//   bus (slave)         : in_pix/in_valid/in_ready source stream,
//                         out_pix/out_valid/out_ready + out_sof/out_eol/out_last
//   crop_x, crop_y      : window origin, latched on an accepted start
//   start               : begin readout (honoured only while a frame is held and idle)
//   frame_full          : frame stored, readout may start
//   frame_done          : 1-cycle pulse after the last crop pixel is accepted
//   err_bounds          : 1-cycle pulse, start rejected (window outside frame)
// Option macro FRAME_CROP_REPLAY_EN: frame is kept after readout for further crops;
//   adds input new_frame which discards it and returns to filling.
module frame_crop_buffer #(
  parameter int PIX_W  = 8,
  parameter int SRC_W  = 330,
  parameter int SRC_H  = 110,
  parameter int CROP_W = 300,
  parameter int CROP_H = 100,
  parameter int ADDR_W = 16,
  parameter int POS_W  = 10
) (
  input  logic             clk,
  input  logic             reset,
  frame_crop_if.slave      bus,
  input  logic [POS_W-1:0] crop_x,
  input  logic [POS_W-1:0] crop_y,
  input  logic             start,
`ifdef FRAME_CROP_REPLAY_EN
  input  logic             new_frame,
`endif
  output logic             frame_full,
  output logic             frame_done,
  output logic             err_bounds
);
  localparam int NPIX   = SRC_W * SRC_H;
  localparam int MEM_AW = $clog2(NPIX);
  localparam int COL_W  = $clog2(CROP_W + 1);
  localparam int ROW_W  = $clog2(CROP_H + 1);
  localparam int STAGES = 2;  // stage 1 = memory read, stage 2 = output register
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W-1:0] SRC_W_A  = ADDR_W'(SRC_W);

  typedef enum logic [1:0] {S_FILL, S_WAIT, S_DRAIN} state_e;
  typedef struct packed {logic sof; logic eol; logic last;} mark_t;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     wr_idx_q, wr_idx_d;
  logic [POS_W-1:0]      cx_q, cx_d, cy_q, cy_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [COL_W-1:0]      col_q, col_d;
  // vld_pipe[0] = address generator still issuing; [STAGES] = out_valid
  logic [STAGES:0]       vld_pipe_q, vld_pipe_d;
  mark_t [STAGES:1]      mark_q, mark_d;
  logic [PIX_W-1:0]      pix_q, pix_d;
  logic                  done_q, done_d, err_q, err_d;

  logic [PIX_W-1:0]      mem [NPIX];
  logic [PIX_W-1:0]      rd_pix_q;
  logic [ADDR_W-1:0]     rd_addr;
  logic                  wr_en, rd_en, adv, oob;
  mark_t                 m0;

  // Whole read pipeline moves in lockstep; a stalled output freezes every stage.
  assign adv = !vld_pipe_q[STAGES] || bus.out_ready;
  assign rd_addr = (ADDR_W'(cy_q) + ADDR_W'(row_q)) * SRC_W_A + ADDR_W'(cx_q) + ADDR_W'(col_q);
  assign m0.sof  = (row_q == '0) && (col_q == '0);
  assign m0.eol  = (col_q == COL_W'(CROP_W - 1));
  assign m0.last = m0.eol && (row_q == ROW_W'(CROP_H - 1));
  assign oob = (int'(crop_x) + CROP_W > SRC_W) || (int'(crop_y) + CROP_H > SRC_H);

  always_comb begin
    state_d    = state_q;
    wr_idx_d   = wr_idx_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    row_d      = row_q;
    col_d      = col_q;
    vld_pipe_d = vld_pipe_q;
    mark_d     = mark_q;
    pix_d      = pix_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    case (state_q)
      S_FILL: begin
        if (bus.in_valid) begin
          wr_en = 1'b1;
          if (wr_idx_q == LAST_IDX) begin
            state_d  = S_WAIT;
            wr_idx_d = '0;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
      end
      S_WAIT: begin
`ifdef FRAME_CROP_REPLAY_EN
        if (new_frame) begin
          state_d  = S_FILL;
          wr_idx_d = '0;
        end else
`endif
        if (start) begin
          cx_d = crop_x;
          cy_d = crop_y;
          if (oob) begin
            err_d = 1'b1;
          end else begin
            state_d       = S_DRAIN;
            row_d         = '0;
            col_d         = '0;
            vld_pipe_d[0] = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (adv) begin
          rd_en                   = vld_pipe_q[0];
          vld_pipe_d[STAGES:1]    = vld_pipe_q[STAGES-1:0];
          mark_d[1]               = m0;
          mark_d[2]               = mark_q[1];
          pix_d                   = rd_pix_q;
          if (vld_pipe_q[0]) begin
            if (m0.last) vld_pipe_d[0] = 1'b0;
            if (m0.eol) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
          if (vld_pipe_q[STAGES] && bus.out_ready && mark_q[STAGES].last) begin
            done_d     = 1'b1;
            vld_pipe_d = '0;
            wr_idx_d   = '0;
`ifdef FRAME_CROP_REPLAY_EN
            state_d    = S_WAIT;
`else
            state_d    = S_FILL;
`endif
          end
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FILL;
      wr_idx_q   <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      row_q      <= '0;
      col_q      <= '0;
      vld_pipe_q <= '0;
      mark_q     <= '0;
      pix_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      row_q      <= row_d;
      col_q      <= col_d;
      vld_pipe_q <= vld_pipe_d;
      mark_q     <= mark_d;
      pix_q      <= pix_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Frame store: contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx_q[MEM_AW-1:0]] <= bus.in_pix;
    if (rd_en) rd_pix_q <= mem[rd_addr[MEM_AW-1:0]];
  end

  assign bus.in_ready  = (state_q == S_FILL);
  assign bus.out_valid = vld_pipe_q[STAGES];
  assign bus.out_pix   = pix_q;
  assign bus.out_sof   = mark_q[STAGES].sof;
  assign bus.out_eol   = mark_q[STAGES].eol;
  assign bus.out_last  = mark_q[STAGES].last;
  assign frame_full    = (state_q != S_FILL);
  assign frame_done    = done_q;
  assign err_bounds    = err_q;
endmodule

// File: tb/tb_frame_crop_buffer.sv
module tb_frame_crop_buffer;
  localparam int PIX_W = 8, SRC_W = 33, SRC_H = 11, CROP_W = 30, CROP_H = 10;
  localparam int ADDR_W = 16, POS_W = 10;
  localparam int NPIX = SRC_W * SRC_H, NOUT = CROP_W * CROP_H;
`ifdef FRAME_CROP_REPLAY_EN
  localparam bit REPLAY = 1'b1;
`else
  localparam bit REPLAY = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  logic [POS_W-1:0] crop_x = '0, crop_y = '0;
  logic start = 1'b0;
  logic frame_full, frame_done, err_bounds;
`ifdef FRAME_CROP_REPLAY_EN
  logic new_frame = 1'b0;
`endif

  frame_crop_if #(.PIX_W(PIX_W)) bus ();

  frame_crop_buffer #(.PIX_W(PIX_W), .SRC_W(SRC_W), .SRC_H(SRC_H), .CROP_W(CROP_W),
                      .CROP_H(CROP_H), .ADDR_W(ADDR_W), .POS_W(POS_W)) dut (
    .clk(clk), .reset(reset), .bus(bus), .crop_x(crop_x), .crop_y(crop_y), .start(start),
`ifdef FRAME_CROP_REPLAY_EN
    .new_frame(new_frame),
`endif
    .frame_full(frame_full), .frame_done(frame_done), .err_bounds(err_bounds));

  int n_chk = 0, n_fail = 0;
  int need_fill = 1, cur_ofs = 0;

  typedef struct {
    int cx, cy, ofs;
    bit stall, exp_err;
    int exp_first, exp_last;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fill(input int ofs, input bit gaps, input bit poke_start);
    int sent = 0, cyc = 0;
    bit err_seen = 0, poked = 0;
    while (sent < NPIX && cyc < 4 * NPIX) begin
      @(negedge clk); cyc++;
      if (err_bounds) err_seen = 1;
      start = 1'b0;
      if (poke_start && !poked && sent == NPIX / 2) begin
        start = 1'b1; crop_x = 40; crop_y = 40; poked = 1;
      end
      bus.in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.in_pix   = 8'((sent + ofs) % 256);
      if (bus.in_valid && bus.in_ready) sent++;
    end
    @(negedge clk);
    start = 1'b0; bus.in_valid = 1'b0;
    if (err_bounds) err_seen = 1;
    check("fill_count", sent, NPIX);
    check("fill_start_ignored", err_seen, 0);
    check("wait_frame_full", frame_full, 1);
    check("wait_in_ready", bus.in_ready, 0);
    bus.in_valid = 1'b1; bus.in_pix = 8'hEE;  // must not touch the stored frame
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    check("wait_in_ready_hold", bus.in_ready, 0);
  endtask

  task automatic do_start(input int cx, input int cy, input bit exp_err);
    @(negedge clk);
    crop_x = POS_W'(cx); crop_y = POS_W'(cy); start = 1'b1;
    @(negedge clk);
    start = 1'b0; crop_x = POS_W'(cx ^ 5); crop_y = POS_W'(cy ^ 3);
    check("err_bounds", err_bounds, exp_err);
    check("valid_lat1", bus.out_valid, 0);
    @(negedge clk);
    check("valid_lat2", bus.out_valid, 0);
    if (exp_err) begin
      check("err_pulse", err_bounds, 0);
      check("err_full_kept", frame_full, 1);
    end
  endtask

  task automatic drain(input int cx, input int cy, input int ofs, input bit stall,
                       input int stop_at, input int exp_first, input int exp_last,
                       input bit inject_start);
    int got = 0, cyc = 0, eols = 0, idx;
    bit held_v = 0;
    logic [10:0] held, cur, expv;
    while (got < stop_at && cyc < 20 * NOUT) begin
      @(negedge clk); cyc++;
      cur = {bus.out_pix, bus.out_sof, bus.out_eol, bus.out_last};
      if (cyc == 1) check("valid_rise", bus.out_valid, 1);
      if (held_v) check("stall_hold", {bus.out_valid, cur}, {1'b1, held});
      if (inject_start && cyc == 40) begin
        start = 1'b1; crop_x = '0; crop_y = '0;
      end else start = 1'b0;
      bus.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      held_v = 0;
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          idx  = (cy + got / CROP_W) * SRC_W + cx + got % CROP_W;
          expv = {8'((idx + ofs) % 256), got == 0, (got % CROP_W) == CROP_W - 1, got == NOUT - 1};
          check("pixel", cur, expv);
          if (got == 0) check("first_pix", bus.out_pix, exp_first);
          if (got == NOUT - 1) check("last_pix", bus.out_pix, exp_last);
          if (bus.out_eol) eols++;
          got++;
        end else begin
          held_v = 1; held = cur;
        end
      end
    end
    start = 1'b0;
    check("drain_count", got, stop_at);
    if (stop_at == NOUT) begin
      check("eol_total", eols, CROP_H);
      @(negedge clk);
      bus.out_ready = 1'b1;
      check("frame_done", frame_done, 1);
      check("done_valid_low", bus.out_valid, 0);
      check("done_frame_full", frame_full, REPLAY ? 1 : 0);
      @(negedge clk);
      check("done_pulse", frame_done, 0);
      check("done_in_ready", bus.in_ready, REPLAY ? 0 : 1);
    end
  endtask

`ifdef FRAME_CROP_REPLAY_EN
  task automatic pulse_new_frame();
    @(negedge clk);
    new_frame = 1'b1; start = 1'b1; crop_x = '0; crop_y = '0;
    @(negedge clk);
    new_frame = 1'b0; start = 1'b0;
    check("nf_in_ready", bus.in_ready, 1);
    check("nf_frame_full", frame_full, 0);
    @(negedge clk);
    check("nf_no_valid", bus.out_valid, 0);
  endtask
`endif

  task automatic run_rec(input vec_t v);
    if (need_fill != 0) begin
`ifdef FRAME_CROP_REPLAY_EN
      if (frame_full) pulse_new_frame();
`endif
      fill(v.ofs, v.stall, v.stall);
      need_fill = 0; cur_ofs = v.ofs;
    end
    do_start(v.cx, v.cy, v.exp_err);
    if (!v.exp_err) begin
      drain(v.cx, v.cy, cur_ofs, v.stall, NOUT, v.exp_first, v.exp_last, v.stall);
      need_fill = 1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            cx cy  ofs stall err first  last
    tbl[0] = '{3, 1, 8'h00, 0, 0, 8'h24, 8'h6A};  // max-extent window
    tbl[1] = '{0, 0, 8'h10, 0, 0, 8'h10, 8'h56};  // origin window
    tbl[2] = '{4, 1, 8'h00, 0, 1, 0, 0};          // one column too far right
    tbl[3] = '{3, 2, 8'h00, 0, 1, 0, 0};          // one line too far down
    tbl[4] = '{3, 1, 8'h00, 1, 0, 8'h24, 8'h6A};  // same frame, random backpressure
    tbl[5] = '{1, 0, 8'h80, 1, 0, 8'h81, 8'hC7};

    bus.in_valid = 1'b0; bus.in_pix = '0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_markers", {bus.out_sof, bus.out_eol, bus.out_last, bus.out_pix}, 0);
    check("rst_flags", {frame_full, frame_done, err_bounds}, 0);

    for (int i = 0; i < 6; i++) run_rec(tbl[i]);

    // Reset part-way through a readout.
    fill(8'h33, 0, 0);
    do_start(0, 0, 0);
    drain(0, 0, 8'h33, 0, 50, 8'h33, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_frame_full", frame_full, 0);
    reset = 1'b0;
    need_fill = 1;
    run_rec(tbl[0]);

`ifdef FRAME_CROP_REPLAY_EN
    // Second crop of the same stored frame, then discard it.
    do_start(0, 0, 0);
    drain(0, 0, 0, 0, NOUT, 8'h00, 8'h46, 0);
    pulse_new_frame();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
